rr_arbiter_4: RTL
=================

# rr_arbiter_4

Four-requester round-robin arbiter that shares a single downstream resource among requesters `req[3:0]`. It issues a registered one-hot grant and the matching 2-bit encoded index, using the same index mapping as the 4-to-2 encoder: bit 3 maps to index 3, bit 0 maps to index 0. A grant is held until the owner drops its request or a programmable hold limit expires. The block sits in front of any shared datapath that needs one owner at a time.

## Interface
- `HOLD_LIMIT`, default 16: maximum consecutive grant cycles per owner, range 0–255. A value of 0 disables the timeout.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous reset, active-low.
- `req` input 4: request lines, level-sensitive, one per requester.
- `gnt` output 4: registered one-hot grant, or 4'b0000 when there is no owner.
- `gnt_idx` output 2: encoded index of the owner; 2'd0 when `gnt_valid` = 0.
- `gnt_valid` output 1: high when `gnt` is nonzero.
- `timeout` output 1: one-cycle pulse marking a forced release.

## Operation
- Internal state:
  - FSM with two states, IDLE and BUSY.
  - 2-bit priority pointer `ptr`.
  - 8-bit counter `hold_cnt`.
- Reset (any edge with `rst_n` = 0), regardless of the current state:
  - state = IDLE, `ptr` = 0, `hold_cnt` = 0.
  - `gnt` = 0, `gnt_idx` = 0, `gnt_valid` = 0, `timeout` = 0.
- IDLE, `req` = 0: stay in IDLE; outputs stay 0; `timeout` clears.
- IDLE, `req` ≠ 0:
  - Winner = first set bit searching `ptr`, `ptr`+1, `ptr`+2, `ptr`+3, all mod 4.
  - Set `gnt` = one-hot(winner), `gnt_idx` = winner, `gnt_valid` = 1, `hold_cnt` = 0, `timeout` = 0.
  - Go to BUSY.
- BUSY, `req[gnt_idx]` = 0 (normal release):
  - `gnt`/`gnt_idx`/`gnt_valid` → 0.
  - `ptr` = `gnt_idx`+1 (2-bit wrap, so 3 → 0).
  - Go to IDLE.
- BUSY, `req[gnt_idx]` = 1, `HOLD_LIMIT` ≠ 0 and `hold_cnt` = `HOLD_LIMIT`−1 (forced release):
  - Same actions as a normal release, plus `timeout` = 1.
- BUSY, otherwise: hold the grant; `hold_cnt` += 1.
  - With `HOLD_LIMIT` = 0 the counter saturates at 255 and never forces a release.
- Requests from non-owners in BUSY are ignored; they do not affect the grant or the pointer.
- After a forced release, the timed-out requester may win again only after the pointer has passed the other active requesters. If it is the sole requester, it wins on the next IDLE arbitration.
- The encoded index always equals the encoder function of `gnt`: `gnt_idx[0]` = `gnt[1]` | `gnt[3]`, `gnt_idx[1]` = `gnt[2]` | `gnt[3]`.

## Timing
- All outputs are registered; there is no combinational path from `req` to any output.
- Grant latency: `req` sampled at edge E while IDLE → `gnt` valid in the cycle after E.
- Release latency: owner `req` low at edge E → `gnt` = 0 in the cycle after E.
- One mandatory idle cycle (`gnt` = 0) separates consecutive grants, including grants back to the same requester.
- Maximum grant length is exactly `HOLD_LIMIT` cycles.
- `timeout` is high only during the idle cycle that follows a forced release.
- If the owner drops `req` on the same edge as the limit is reached, that is a normal release: `timeout` = 0.
- Reset takes priority over every other event, including a grant that is in progress.

## Test plan
- Reset: `rst_n` = 0 for 2 cycles with `req` = 4'b1111 → `gnt` = 0, `gnt_idx` = 0, `gnt_valid` = 0, `timeout` = 0. After release, the first grant is to requester 0 (`gnt` = 4'b0001) one cycle later.
- Single requester: `req` = 4'b0100 for 5 cycles, then 0 → `gnt` = 4'b0100, `gnt_idx` = 2 starting one cycle after the request. The grant lasts 5 cycles, then `gnt` = 0 one cycle after `req[2]` falls; `ptr` = 3.
- Rotation: `req` = 4'b1111, with each owner dropping its request 3 cycles into its grant and re-raising it 1 cycle later → grant order 0, 1, 2, 3, 0. Each grant is 3 cycles, separated by a 1-cycle gap, and `gnt_idx` always matches `gnt`.
- Timeout: `HOLD_LIMIT` = 4, `req[1]` stuck high, `req[3]` high → `gnt` = 4'b0010 for exactly 4 cycles. `timeout` = 1 for 1 cycle with `gnt` = 0, then `gnt` = 4'b1000, `gnt_idx` = 3.
- Reset mid-grant: owner 2 has held the grant for 2 cycles, then `rst_n` = 0 for 1 edge → all outputs 0 in the next cycle. With `req` = 4'b0100 still high, `gnt` = 4'b0100 in the cycle after reset releases (`ptr` = 0, searched to index 2).
- No-timeout mode: `HOLD_LIMIT` = 0, `req[0]` held for 300 cycles with `req[2]` also high → `gnt` = 4'b0001 continuously and `timeout` never asserts. `gnt[2]` arrives 2 cycles after `req[0]` falls (1 release cycle, 1 idle cycle).

Source files
------------

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The master side drives requests; the slave side (the arbiter) answers
// with a registered grant, its encoded index, a valid flag and a timeout pulse.
interface rr_arbiter_4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a programmable hold limit.
// One owner at a time; a grant ends when the owner drops req or after
// HOLD_LIMIT consecutive cycles (0 = no limit). Every grant is followed by
// one idle cycle, in which the priority pointer has already moved past the
// previous owner.
module rr_arbiter_4 #(
  parameter int unsigned HOLD_LIMIT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter_4_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Terminal count for a forced release; unused when the limit is disabled.
  localparam bit         LIMIT_EN = (HOLD_LIMIT != 0);
  localparam logic [7:0] LIMIT_M1 = LIMIT_EN ? 8'(HOLD_LIMIT - 1) : 8'd0;

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] hold_cnt;
  logic [3:0] gnt_q;
  logic [1:0] gnt_idx_q;
  logic       gnt_valid_q;
  logic       timeout_q;

  logic [1:0] win;
  logic       owner_req;
  logic       limit_hit;

  // Winner search: first set request starting at ptr, wrapping mod 4.
  // Walking the offsets from far to near leaves the nearest hit in win.
  always_comb begin
    win = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[ptr + 2'(k)]) win = ptr + 2'(k);
    end
  end

  // Owner still requesting, and whether this is its last allowed cycle.
  always_comb begin
    owner_req = bus.req[gnt_idx_q];
    limit_hit = LIMIT_EN && (hold_cnt == LIMIT_M1);
  end

  // Arbitration FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      hold_cnt    <= 8'd0;
      gnt_q       <= 4'b0000;
      gnt_idx_q   <= 2'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timeout_q <= 1'b0;
          if (|bus.req) begin
            gnt_q       <= 4'b0001 << win;
            gnt_idx_q   <= win;
            gnt_valid_q <= 1'b1;
            hold_cnt    <= 8'd0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (!owner_req || limit_hit) begin
            // Release: the pointer skips past the old owner so that a
            // timed-out requester yields to everyone else still waiting.
            gnt_q       <= 4'b0000;
            gnt_idx_q   <= 2'd0;
            gnt_valid_q <= 1'b0;
            ptr         <= gnt_idx_q + 2'd1;
            timeout_q   <= owner_req;   // only a forced release gets here with req high
            state       <= IDLE;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule
